// File: rtl/wand_pkg.sv
// Shared wand definitions: word types, fixed START/END colours, string
// geometry defaults and the string sequencer state/phase encodings.
package wand_pkg;

  localparam logic [1:0] INPUT_TYPE_START = 2'd0;
  localparam logic [1:0] INPUT_TYPE_LED   = 2'd1;
  localparam logic [1:0] INPUT_TYPE_END   = 2'd2;

  localparam logic [7:0] COLOR_START = 8'h00;
  localparam logic [7:0] COLOR_END   = 8'hFF;

  localparam int STRING_SIZE_DEFAULT    = 47;
  localparam int NUMBER_STRINGS_DEFAULT = 47;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam logic [1:0] PH_START = 2'd0;
  localparam logic [1:0] PH_LED   = 2'd1;
  localparam logic [1:0] PH_END   = 2'd2;

  typedef struct packed {
    logic [1:0] word_type;
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
  } doled_word_t;

  function automatic doled_word_t make_word(input logic [1:0] word_type,
                                            input logic [7:0] blue,
                                            input logic [7:0] green,
                                            input logic [7:0] red);
    doled_word_t w;
    w.word_type = word_type;
    w.blue      = blue;
    w.green     = green;
    w.red       = red;
    return w;
  endfunction

endpackage

// File: rtl/wand_string_sequencer_if.sv
// Pixel-source handshake and doled word bus seen by the string sequencer.
// master = the sequencer, slave = the pattern source plus doled side.
interface wand_string_sequencer_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_blue;
  logic [7:0] pix_green;
  logic [7:0] pix_red;
  logic [7:0] pix_string_idx;
  logic [7:0] pix_led_idx;
  logic [1:0] doled_type;
  logic [7:0] doled_blue;
  logic [7:0] doled_green;
  logic [7:0] doled_red;
  logic       doled_start;
  logic       doled_busy;

  modport master (
    input  pix_valid, pix_blue, pix_green, pix_red, doled_busy,
    output pix_ready, pix_string_idx, pix_led_idx,
           doled_type, doled_blue, doled_green, doled_red, doled_start
  );

  modport slave (
    output pix_valid, pix_blue, pix_green, pix_red, doled_busy,
    input  pix_ready, pix_string_idx, pix_led_idx,
           doled_type, doled_blue, doled_green, doled_red, doled_start
  );
endinterface

// File: rtl/wand_dwell_timer.sv
// Loadable down-counter used for the dwell gap between strings.
// Load has priority over decrement; the count holds at zero.
module wand_dwell_timer #(
  parameter int WIDTH = 16
) (
  input  logic             dostring_clk,
  input  logic             dostring_reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: load, else saturating decrement
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // count register, cleared by reset
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/wand_string_sequencer.sv
// Sequences doled one string at a time: START word, STRING_SIZE LED words
// pulled from the pixel source, END word, then a dwell gap before the next
// string index. The sole driver of doled_start.
module wand_string_sequencer
  import wand_pkg::*;
#(
  parameter int STRING_SIZE    = STRING_SIZE_DEFAULT,
  parameter int NUMBER_STRINGS = NUMBER_STRINGS_DEFAULT,
  parameter int GAP_CYCLES     = 1000,
  parameter int GAP_WIDTH      = 16
) (
  input  logic                    dostring_clk,
  input  logic                    dostring_reset,
  input  logic                    enable,
  wand_string_sequencer_if.master bus,
  output logic                    string_done,
  output logic                    frame_done,
  output logic                    seq_active
);

  localparam logic [7:0]           LAST_LED    = 8'(STRING_SIZE - 1);
  localparam logic [7:0]           LAST_STRING = 8'(NUMBER_STRINGS - 1);
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD    = GAP_WIDTH'(GAP_CYCLES);

  logic [2:0]           state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [7:0]           led_idx_q, led_idx_d;
  logic [7:0]           string_idx_q, string_idx_d;
  doled_word_t          word_q, word_d;
  logic                 string_done_q, string_done_d;
  logic                 frame_done_q, frame_done_d;
  logic                 gap_load;
  logic                 gap_dec;
  logic [GAP_WIDTH-1:0] gap_count;
  logic                 gap_zero;
  logic                 end_drain;
  logic                 gap_end;

  wand_dwell_timer #(
    .WIDTH(GAP_WIDTH)
  ) u_dwell_timer (
    .dostring_clk  (dostring_clk),
    .dostring_reset(dostring_reset),
    .load_i        (gap_load),
    .load_value_i  (GAP_LOAD),
    .dec_i         (gap_dec),
    .count_o       (gap_count),
    .zero_o        (gap_zero)
  );

  // The END word's drain completing; with no dwell it also ends the gap.
  assign end_drain = (state_q == ST_DRAIN) && !bus.doled_busy && (phase_q == PH_END);
  // Gap ends on the cycle whose decrement reaches zero, so it lasts GAP_CYCLES clocks.
  assign gap_end = ((state_q == ST_GAP) && (gap_zero || (gap_count == GAP_WIDTH'(1))))
                || (end_drain && (GAP_CYCLES == 0));

  // next-state logic for the whole string/word sequence
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    led_idx_d     = led_idx_q;
    string_idx_d  = string_idx_q;
    word_d        = word_q;
    string_done_d = 1'b0;
    frame_done_d  = 1'b0;
    gap_load      = 1'b0;
    gap_dec       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_FETCH;
          phase_d   = PH_START;
          led_idx_d = '0;
        end
      end
      ST_FETCH: begin
        if (!bus.doled_busy) begin
          case (phase_q)
            PH_START: begin
              word_d  = make_word(INPUT_TYPE_START, COLOR_START, COLOR_START, COLOR_START);
              state_d = ST_ISSUE;
            end
            PH_LED: begin
              if (bus.pix_valid) begin
                word_d  = make_word(INPUT_TYPE_LED, bus.pix_blue, bus.pix_green, bus.pix_red);
                state_d = ST_ISSUE;
              end
            end
            default: begin
              word_d  = make_word(INPUT_TYPE_END, COLOR_END, COLOR_END, COLOR_END);
              state_d = ST_ISSUE;
            end
          endcase
        end
      end
      ST_ISSUE: state_d = ST_HOLD;
      // doled only raises busy the cycle after start, so skip one look at it
      ST_HOLD:  state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.doled_busy) begin
          state_d = ST_FETCH;
          case (phase_q)
            PH_START: phase_d = PH_LED;
            PH_LED: begin
              if (led_idx_q == LAST_LED) begin
                phase_d = PH_END;
              end else begin
                led_idx_d = led_idx_q + 8'd1;
              end
            end
            default: begin
              string_done_d = 1'b1;
              if (string_idx_q == LAST_STRING) begin
                string_idx_d = '0;
                frame_done_d = 1'b1;
              end else begin
                string_idx_d = string_idx_q + 8'd1;
              end
              gap_load = 1'b1;
              state_d  = ST_GAP;
            end
          endcase
        end
      end
      ST_GAP:  gap_dec = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // enable is only consulted here and in IDLE, so strings are never cut short
    if (gap_end) begin
      if (enable) begin
        state_d   = ST_FETCH;
        phase_d   = PH_START;
        led_idx_d = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // sequencer state registers; reset abandons any partial string
  always_ff @(posedge dostring_clk or posedge dostring_reset) begin
    if (dostring_reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_START;
      led_idx_q     <= '0;
      string_idx_q  <= '0;
      word_q        <= '0;
      string_done_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      led_idx_q     <= led_idx_d;
      string_idx_q  <= string_idx_d;
      word_q        <= word_d;
      string_done_q <= string_done_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.pix_ready      = (state_q == ST_FETCH) && (phase_q == PH_LED) && !bus.doled_busy;
  assign bus.pix_string_idx = string_idx_q;
  assign bus.pix_led_idx    = led_idx_q;
  assign bus.doled_type     = word_q.word_type;
  assign bus.doled_blue     = word_q.blue;
  assign bus.doled_green    = word_q.green;
  assign bus.doled_red      = word_q.red;
  assign bus.doled_start    = (state_q == ST_ISSUE);
  assign string_done        = string_done_q;
  assign frame_done         = frame_done_q;
  assign seq_active         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wand_string_sequencer.sv
// Directed bench for wand_string_sequencer: a 3-LED, 2-string configuration
// with a 5-clock gap (dut_a) and the same with no gap (dut_b), each driving
// a doled model that stays busy for 8 clocks per word.
module tb_wand_string_sequencer;
  import wand_pkg::*;

  localparam int BUSY_CYCLES = 8;
  localparam int TIMEOUT     = 600;

  typedef struct {
    logic [1:0]  t;
    logic [23:0] col;
    logic [7:0]  si;
    logic [7:0]  li;
    int          cyc;
  } word_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable_a = 1'b0;
  logic enable_b = 1'b0;
  logic string_done_a, frame_done_a, seq_active_a;
  logic string_done_b, frame_done_b, seq_active_b;

  int errors = 0;
  int checks = 0;

  wand_string_sequencer_if bus_a ();
  wand_string_sequencer_if bus_b ();

  wand_string_sequencer #(
    .STRING_SIZE(3), .NUMBER_STRINGS(2), .GAP_CYCLES(5), .GAP_WIDTH(16)
  ) dut_a (
    .dostring_clk(clk), .dostring_reset(rst), .enable(enable_a), .bus(bus_a),
    .string_done(string_done_a), .frame_done(frame_done_a), .seq_active(seq_active_a)
  );

  wand_string_sequencer #(
    .STRING_SIZE(3), .NUMBER_STRINGS(2), .GAP_CYCLES(0), .GAP_WIDTH(16)
  ) dut_b (
    .dostring_clk(clk), .dostring_reset(rst), .enable(enable_b), .bus(bus_b),
    .string_done(string_done_b), .frame_done(frame_done_b), .seq_active(seq_active_b)
  );

  always #5 clk = ~clk;

  // pixel source: colour is a fixed function of the requested position
  assign bus_a.pix_blue  = 8'hA0 ^ bus_a.pix_led_idx;
  assign bus_a.pix_green = 8'h50 ^ bus_a.pix_string_idx;
  assign bus_a.pix_red   = 8'h0F + bus_a.pix_led_idx;
  assign bus_b.pix_blue  = 8'hA0 ^ bus_b.pix_led_idx;
  assign bus_b.pix_green = 8'h50 ^ bus_b.pix_string_idx;
  assign bus_b.pix_red   = 8'h0F + bus_b.pix_led_idx;

  // doled models: busy from the cycle after start for BUSY_CYCLES clocks
  int busy_cnt_a, busy_cnt_b;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt_a <= 0;
    else if (bus_a.doled_start) busy_cnt_a <= BUSY_CYCLES;
    else if (busy_cnt_a != 0) busy_cnt_a <= busy_cnt_a - 1;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt_b <= 0;
    else if (bus_b.doled_start) busy_cnt_b <= BUSY_CYCLES;
    else if (busy_cnt_b != 0) busy_cnt_b <= busy_cnt_b - 1;
  end
  assign bus_a.doled_busy = (busy_cnt_a != 0);
  assign bus_b.doled_busy = (busy_cnt_b != 0);

  // mid-cycle monitor: one sample per clock
  word_rec_t word_log[$];
  int cyc = 0;
  int start_count_a = 0, busy_viol = 0, sd_count = 0, sd_cycle = 0, fd_count = 0;
  int start_count_b = 0, sd_b_count = 0, sd_b_cyc = 0, start_b_cyc = 0;
  logic [1:0] start_b_type;
  always @(negedge clk) begin
    word_rec_t r;
    cyc = cyc + 1;
    if (bus_a.doled_start) begin
      r.t   = bus_a.doled_type;
      r.col = {bus_a.doled_blue, bus_a.doled_green, bus_a.doled_red};
      r.si  = bus_a.pix_string_idx;
      r.li  = bus_a.pix_led_idx;
      r.cyc = cyc;
      word_log.push_back(r);
      start_count_a = start_count_a + 1;
      if (bus_a.doled_busy) busy_viol = busy_viol + 1;
    end
    if (string_done_a) begin
      sd_cycle = cyc;
      sd_count = sd_count + 1;
      if (frame_done_a) fd_count = fd_count + 1;
    end
    if (bus_b.doled_start) begin
      start_count_b = start_count_b + 1;
      start_b_cyc   = cyc;
      start_b_type  = bus_b.doled_type;
    end
    if (string_done_b) begin
      sd_b_count = sd_b_count + 1;
      sd_b_cyc   = cyc;
    end
  end

  function automatic logic [23:0] exp_led(input int s, input int i);
    logic [7:0] b, g, r;
    b = 8'hA0 ^ 8'(i);
    g = 8'h50 ^ 8'(s);
    r = 8'h0F + 8'(i);
    return {b, g, r};
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_sd(input int prev, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < TIMEOUT; n++) begin
      tick();
      if (sd_count > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable_a = 1'b0;
    enable_b = 1'b0;
    bus_a.pix_valid = 1'b1;
    bus_b.pix_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus_a.pix_ready, bus_a.doled_start, string_done_a, frame_done_a, seq_active_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, want 00000",
               {bus_a.pix_ready, bus_a.doled_start, string_done_a, frame_done_a, seq_active_a});
    end
    checks++;
    if ({bus_a.pix_string_idx, bus_a.pix_led_idx} !== 16'h0) begin
      errors++;
      $display("FAIL reset_idx: got %h, want 0000", {bus_a.pix_string_idx, bus_a.pix_led_idx});
    end
    checks++;
    if ({bus_a.doled_type, bus_a.doled_blue, bus_a.doled_green, bus_a.doled_red} !== 26'h0) begin
      errors++;
      $display("FAIL reset_word: got %h, want 0",
               {bus_a.doled_type, bus_a.doled_blue, bus_a.doled_green, bus_a.doled_red});
    end
    checks++;
    if ({seq_active_b, bus_b.doled_start} !== 2'b00) begin
      errors++;
      $display("FAIL reset_b: got %b, want 00", {seq_active_b, bus_b.doled_start});
    end
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (seq_active_a !== 1'b0 || start_count_a != 0) begin
      errors++;
      $display("FAIL idle_no_enable: seq_active=%b starts=%0d, want 0 and 0", seq_active_a, start_count_a);
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_string_frame();
    bit ok;
    int prev, sd0;
    word_log.delete();
    prev = sd_count;
    enable_a = 1'b1;
    wait_sd(prev, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL string0_timeout: no string_done in %0d cycles", TIMEOUT); end
    checks++;
    if (word_log.size() != 5) begin
      errors++;
      $display("FAIL string0_words: got %0d starts, want 5", word_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        logic [1:0]  et;
        logic [23:0] ec;
        et = (k == 0) ? INPUT_TYPE_START : (k == 4) ? INPUT_TYPE_END : INPUT_TYPE_LED;
        ec = (k == 0) ? 24'h000000 : (k == 4) ? 24'hFFFFFF : exp_led(0, k - 1);
        checks++;
        if (word_log[k].t !== et || word_log[k].col !== ec || word_log[k].si !== 8'd0) begin
          errors++;
          $display("FAIL string0_word%0d: got type=%0d col=%h si=%0d, want type=%0d col=%h si=0",
                   k, word_log[k].t, word_log[k].col, word_log[k].si, et, ec);
        end
      end
    end
    checks++;
    if (frame_done_a !== 1'b0 || bus_a.pix_string_idx !== 8'd1) begin
      errors++;
      $display("FAIL string0_done: frame_done=%b string_idx=%0d, want 0 and 1", frame_done_a, bus_a.pix_string_idx);
    end
    sd0 = sd_cycle;
    word_log.delete();
    prev = sd_count;
    wait_sd(prev, ok);
    checks++;
    if (!ok || word_log.size() != 5) begin
      errors++;
      $display("FAIL string1_words: done=%0d starts=%0d, want 1 and 5", ok, word_log.size());
    end
    checks++;
    if (word_log.size() > 0 && word_log[0].cyc - sd0 != 6) begin
      errors++;
      $display("FAIL gap5_latency: string_done to next start %0d cycles, want 6", word_log[0].cyc - sd0);
    end
    checks++;
    if (frame_done_a !== 1'b1 || string_done_a !== 1'b1 || fd_count != 1 || bus_a.pix_string_idx !== 8'd0) begin
      errors++;
      $display("FAIL frame_wrap: frame_done=%b string_done=%b frames=%0d string_idx=%0d, want 1 1 1 0",
               frame_done_a, string_done_a, fd_count, bus_a.pix_string_idx);
    end
    tick();
    checks++;
    if ({string_done_a, frame_done_a} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse_width: got %b, want 00", {string_done_a, frame_done_a});
    end
    $display("test_string_frame done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int prev, viol0;
    word_log.delete();
    prev  = sd_count;
    viol0 = busy_viol;
    wait_sd(prev, ok);
    checks++;
    if (!ok || word_log.size() != 5) begin
      errors++;
      $display("FAIL b2b_start_count: done=%0d starts=%0d, want 1 and 5", ok, word_log.size());
    end
    checks++;
    if (busy_viol != viol0) begin
      errors++;
      $display("FAIL b2b_start_while_busy: got %0d, want 0", busy_viol - viol0);
    end
    for (int k = 1; k < 5 && k < word_log.size(); k++) begin
      checks++;
      if (word_log[k].cyc - word_log[k-1].cyc != 11) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, want 11", k, word_log[k].cyc - word_log[k-1].cyc);
      end
    end
    checks++;
    if (word_log.size() > 0 && (word_log[0].t !== INPUT_TYPE_START || word_log[0].si !== 8'd0)) begin
      errors++;
      $display("FAIL b2b_first_word: type=%0d si=%0d, want 0 0", word_log[0].t, word_log[0].si);
    end
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stall();
    bit ok, found;
    int prev, sc;
    word_log.delete();
    prev  = sd_count;
    found = 1'b0;
    for (int n = 0; n < TIMEOUT; n++) begin
      if (bus_a.pix_ready === 1'b1 && bus_a.pix_led_idx === 8'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_reach_led1: pix_ready on LED 1 not seen"); end
    bus_a.pix_valid = 1'b0;
    sc = start_count_a;
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if (bus_a.pix_ready !== 1'b1 || bus_a.pix_led_idx !== 8'd1) begin
        errors++;
        $display("FAIL stall_hold%0d: pix_ready=%b led_idx=%0d, want 1 and 1", n, bus_a.pix_ready, bus_a.pix_led_idx);
      end
    end
    checks++;
    if (start_count_a != sc) begin
      errors++;
      $display("FAIL stall_no_start: got %0d starts, want 0", start_count_a - sc);
    end
    bus_a.pix_valid = 1'b1;
    wait_sd(prev, ok);
    checks++;
    if (!ok || word_log.size() != 5) begin
      errors++;
      $display("FAIL stall_words: done=%0d starts=%0d, want 1 and 5", ok, word_log.size());
    end else begin
      checks++;
      if (word_log[2].t !== INPUT_TYPE_LED || word_log[2].col !== exp_led(1, 1) || word_log[3].col !== exp_led(1, 2)) begin
        errors++;
        $display("FAIL stall_resume_colour: got %h/%h, want %h/%h",
                 word_log[2].col, word_log[3].col, exp_led(1, 1), exp_led(1, 2));
      end
    end
    $display("test_stall done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_enable_drop();
    bit ok, found;
    int prev, sc;
    word_log.delete();
    prev  = sd_count;
    found = 1'b0;
    for (int n = 0; n < TIMEOUT; n++) begin
      tick();
      if (word_log.size() > 0 && bus_a.pix_led_idx === 8'd2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL drop_reach_led2: LED 2 not reached"); end
    enable_a = 1'b0;
    wait_sd(prev, ok);
    checks++;
    if (!ok || word_log.size() != 5 || word_log[word_log.size()-1].t !== INPUT_TYPE_END) begin
      errors++;
      $display("FAIL drop_completes: done=%0d starts=%0d, want 1 and 5 ending in END", ok, word_log.size());
    end
    sc = start_count_a;
    repeat (12) tick();
    checks++;
    if (seq_active_a !== 1'b0 || start_count_a != sc) begin
      errors++;
      $display("FAIL drop_idle: seq_active=%b extra_starts=%0d, want 0 and 0", seq_active_a, start_count_a - sc);
    end
    $display("test_enable_drop done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_gap_zero();
    bit ok;
    int prev;
    prev = sd_b_count;
    enable_b = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < TIMEOUT; n++) begin
      tick();
      if (sd_b_count > prev) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL gap0_timeout: no string_done in %0d cycles", TIMEOUT); end
    tick();
    checks++;
    if (start_b_cyc - sd_b_cyc != 1 || start_b_type !== INPUT_TYPE_START) begin
      errors++;
      $display("FAIL gap0_restart: start %0d cycles after string_done type=%0d, want 1 and 0",
               start_b_cyc - sd_b_cyc, start_b_type);
    end
    checks++;
    if (bus_b.pix_string_idx !== 8'd1) begin
      errors++;
      $display("FAIL gap0_string_idx: got %0d, want 1", bus_b.pix_string_idx);
    end
    enable_b = 1'b0;
    $display("test_gap_zero done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    bit found;
    enable_a = 1'b1;
    found = 1'b0;
    for (int n = 0; n < TIMEOUT; n++) begin
      tick();
      if (bus_a.doled_start === 1'b1 && bus_a.doled_type === INPUT_TYPE_LED) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach_led: no LED word issued"); end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_a.doled_type, bus_a.doled_blue, bus_a.doled_green, bus_a.doled_red, bus_a.pix_string_idx,
         bus_a.pix_led_idx, bus_a.pix_ready, bus_a.doled_start, string_done_a, frame_done_a, seq_active_a} !== 47'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: type=%0d col=%h si=%0d li=%0d active=%b, want all 0",
               bus_a.doled_type, {bus_a.doled_blue, bus_a.doled_green, bus_a.doled_red},
               bus_a.pix_string_idx, bus_a.pix_led_idx, seq_active_a);
    end
    tick();
    rst = 1'b0;
    word_log.delete();
    found = 1'b0;
    for (int n = 0; n < TIMEOUT; n++) begin
      tick();
      if (word_log.size() > 0) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || word_log[0].t !== INPUT_TYPE_START || word_log[0].si !== 8'd0 || word_log[0].col !== 24'h0) begin
      errors++;
      $display("FAIL rstmid_restart: seen=%0d type=%0d si=%0d, want START at string 0", found,
               found ? word_log[0].t : 2'd3, found ? word_log[0].si : 8'hFF);
    end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_string_frame();
    test_back_to_back();
    test_stall();
    test_enable_drop();
    test_gap_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
